instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Inverse of the decode-stage classifier. Accepts instruction fields plus a format tag (R/I/J) and packs them into a 32-bit MIPS instruction word. It checks that the opcode belongs to the declared format and buffers results in a 2-entry output queue with valid/ready handshakes on both sides. Sits in front of the instruction memory loader and the self-test stimulus path, feeding encoded words to the fetch/IMEM write port.

Parameters:
CHECK_FMT, 1, 1 = flag opcode/format mismatch on out_err; 0 = never flag, encode as tagged.
NOP_WORD, 32'h00000000, word emitted for reserved format tag.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input fields valid
in_ready  output  1  encoder can accept this cycle
in_fmt  input  2  0=R, 1=I, 2=J, 3=reserved
in_opcode  input  6  opcode field [31:26]
in_rs  input  5  R/I rs [25:21]
in_rt  input  5  R/I rt [20:16]
in_rd  input  5  R rd [15:11]
in_shamt  input  5  R shamt [10:6]
in_funct  input  6  R funct [5:0]
in_imm  input  16  I immediate [15:0]
in_target  input  26  J target [25:0]
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_instr  output  32  encoded word at head
out_err  output  1  head entry had format mismatch or reserved tag

Behaviour:
- Reset: queue empty; out_valid=0, out_instr=0, out_err=0, in_ready=1; stats counters (if built) = 0.
- Push when in_valid & in_ready; pop when out_valid & out_ready. Both may occur in the same cycle.
- Packing: R = {opcode,rs,rt,rd,shamt,funct}; I = {opcode,rs,rt,imm}; J = {opcode,target}; fmt 3 = NOP_WORD. Unused input fields are ignored.
- Opcode classes: R = {0x00}; I = {0x01,0x04,0x05,0x09,0x0F,0x23,0x28,0x2B}; J = {0x02,0x03}.
- err = CHECK_FMT & (opcode not in class of fmt); fmt 3 always err=1. An errored word is still encoded from the fields as tagged and still enqueued.
- Latency: a word pushed in cycle N is visible on out_instr/out_valid in cycle N+1 when the queue was empty. No combinational path from in_* to out_*.
- Queue: 2 entries, FIFO order, count 0..2.
- in_ready = (count<2), computed from registered count. Pop at count 2 does not raise in_ready in the same cycle.
- Empty: a pop attempt is ignored. Simultaneous push and pop at count 1 leaves count 1, the new word at head next cycle.
- Full: in_valid is ignored and the input is not consumed. out_instr/out_err stay stable while out_valid & !out_ready.
- rst mid-operation discards all queued entries next edge; inputs that cycle are ignored.

Optional Feature:
ENCODER_STATS_EN: when defined, adds outputs stat_r, stat_i, stat_j, stat_err (16 bits each).
- Counts accepted pushes by in_fmt class; stat_err counts pushes with err=1. A fmt 3 push increments only stat_err.
- Counters saturate at 16'hFFFF and clear on rst.
- When undefined, these ports and the counters do not exist; all other behaviour is identical.

Test Plan:
- R addu: fmt0 op0 rs1 rt2 rd3 shamt0 funct0x21, out_ready=1 -> next cycle out_instr=0x00221821, out_err=0.
- I/J back-to-back: addiu (op0x09 rs0 rt8 imm5), j (op0x02 target0x0100000), lw (op0x23 rs29 rt9 imm4) on consecutive cycles -> 0x24080005, 0x08100000, 0x8FA90004 in order, err=0.
- Backpressure: out_ready=0, push 3 words -> in_ready=0 after 2, third held; raise out_ready -> words drain in order, in_ready returns 1 one cycle after first pop.
- Mismatch: fmt1 with op0x02, imm 0x1234 -> out_instr=0x08001234, out_err=1. With CHECK_FMT=0 -> out_err=0. fmt3 -> out_instr=NOP_WORD, out_err=1.
- Reset mid-stream: 2 entries queued, assert rst one cycle -> out_valid=0, in_ready=1, no stale word emitted after release.
- Stats (ENCODER_STATS_EN): push 2 R, 1 I, 1 mismatched J -> stat_r=2, stat_i=1, stat_j=1, stat_err=1.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs R/I/J instruction fields into a 32-bit MIPS word.
// The opcode is checked against the declared format, and results are buffered
// in a 2-entry FIFO with valid/ready handshakes on both sides.
// Optional build macro ENCODER_STATS_EN adds saturating per-format push counters.
module instr_encoder #(
  parameter bit          CHECK_FMT = 1'b1,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [5:0]  in_opcode,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
`ifdef ENCODER_STATS_EN
  output logic [15:0] stat_r,
  output logic [15:0] stat_i,
  output logic [15:0] stat_j,
  output logic [15:0] stat_err,
`endif
  output logic        out_err
);

  localparam logic [1:0] FmtR = 2'd0;
  localparam logic [1:0] FmtI = 2'd1;
  localparam logic [1:0] FmtJ = 2'd2;

  logic        op_is_r, op_is_i, op_is_j;
  logic [31:0] enc_word;
  logic        enc_err;

  logic [31:0] instr_q [2];
  logic [1:0]  err_q;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr;
  logic        push, pop;

  // Classify the opcode into the format it legally belongs to.
  always_comb begin
    op_is_r = (in_opcode == 6'h00);
    op_is_j = (in_opcode == 6'h02) || (in_opcode == 6'h03);
    op_is_i = 1'b0;
    case (in_opcode)
      6'h01, 6'h04, 6'h05, 6'h09, 6'h0F, 6'h23, 6'h28, 6'h2B: op_is_i = 1'b1;
      default:                                                 op_is_i = 1'b0;
    endcase
  end

  // Pack fields as tagged; a mismatched opcode is still encoded, only flagged.
  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b1;
    unique case (in_fmt)
      FmtR: begin
        enc_word = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
        enc_err  = CHECK_FMT & ~op_is_r;
      end
      FmtI: begin
        enc_word = {in_opcode, in_rs, in_rt, in_imm};
        enc_err  = CHECK_FMT & ~op_is_i;
      end
      FmtJ: begin
        enc_word = {in_opcode, in_target};
        enc_err  = CHECK_FMT & ~op_is_j;
      end
      default: begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Handshakes and next-state for occupancy and read pointer.
  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    // Next free slot sits one past the head when a single entry is held.
    wr_ptr    = rd_ptr_q ^ count_q[0];
    rd_ptr_d  = pop ? ~rd_ptr_q : rd_ptr_q;
    count_d   = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Queue storage, occupancy and head pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      err_q      <= 2'b00;
      instr_q[0] <= 32'h0;
      instr_q[1] <= 32'h0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        instr_q[wr_ptr] <= enc_word;
        err_q[wr_ptr]   <= enc_err;
      end
    end
  end

  // Head outputs are forced to zero when empty so nothing stale is visible.
  always_comb begin
    out_instr = out_valid ? instr_q[rd_ptr_q] : 32'h0;
    out_err   = out_valid ? err_q[rd_ptr_q]   : 1'b0;
  end

`ifdef ENCODER_STATS_EN
  logic [15:0] stat_r_q, stat_i_q, stat_j_q, stat_err_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating counters of accepted pushes; reserved tag only bumps stat_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_r_q   <= 16'h0;
      stat_i_q   <= 16'h0;
      stat_j_q   <= 16'h0;
      stat_err_q <= 16'h0;
    end else if (push) begin
      if (in_fmt == FmtR) stat_r_q <= sat_inc(stat_r_q);
      if (in_fmt == FmtI) stat_i_q <= sat_inc(stat_i_q);
      if (in_fmt == FmtJ) stat_j_q <= sat_inc(stat_j_q);
      if (enc_err)        stat_err_q <= sat_inc(stat_err_q);
    end
  end

  assign stat_r   = stat_r_q;
  assign stat_i   = stat_i_q;
  assign stat_j   = stat_j_q;
  assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: packing, ordering, backpressure, format
// checking (with and without CHECK_FMT), reserved tag and mid-stream reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_fmt;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_ready;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic        nc_in_ready, nc_out_valid, nc_out_err;
  logic [31:0] nc_out_instr;
`ifdef ENCODER_STATS_EN
  logic [15:0] stat_r, stat_i, stat_j, stat_err;
  logic [15:0] nc_stat_r, nc_stat_i, nc_stat_j, nc_stat_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encoder #(.CHECK_FMT(1'b1), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
`ifdef ENCODER_STATS_EN
    .stat_r(stat_r), .stat_i(stat_i), .stat_j(stat_j), .stat_err(stat_err),
`endif
    .out_err(out_err)
  );

  // Second instance with format checking disabled, fed the same stimulus.
  instr_encoder #(.CHECK_FMT(1'b0), .NOP_WORD(32'h0000_0000)) dut_nochk (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nc_in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(nc_out_valid), .out_ready(out_ready), .out_instr(nc_out_instr),
`ifdef ENCODER_STATS_EN
    .stat_r(nc_stat_r), .stat_i(nc_stat_i), .stat_j(nc_stat_j), .stat_err(nc_stat_err),
`endif
    .out_err(nc_out_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] fmt, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_opcode = op;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = sh;
    in_funct  = fn;
    in_imm    = imm;
    in_target = tgt;
  endtask

  task automatic drive_addu();  drive(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0);
  endtask
  task automatic drive_addiu(); drive(2'd1, 6'h09, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h5, 26'h0);
  endtask
  task automatic drive_j();     drive(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000);
  endtask
  task automatic drive_lw();    drive(2'd1, 6'h23, 5'd29, 5'd9, 5'd0, 5'd0, 6'h0, 16'h4, 26'h0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_funct = '0; in_imm = '0; in_target = '0;
    step(); step();
    check_eq("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check_eq("rst_out_instr", out_instr, 32'h0);
    check_eq("rst_out_err", {31'h0, out_err}, 32'h0);
    check_eq("rst_in_ready", {31'h0, in_ready}, 32'h1);
    rst = 1'b0;

    // Single R-type addu
    out_ready = 1'b1;
    drive_addu();
    step();
    in_valid = 1'b0;
    check_eq("addu_valid", {31'h0, out_valid}, 32'h1);
    check_eq("addu_instr", out_instr, 32'h0022_1821);
    check_eq("addu_err", {31'h0, out_err}, 32'h0);
    step();
    check_eq("addu_drained", {31'h0, out_valid}, 32'h0);

    // Back-to-back I/J/I with consumer always ready
    drive_addiu();
    step();
    check_eq("b2b_addiu", out_instr, 32'h2408_0005);
    check_eq("b2b_addiu_err", {31'h0, out_err}, 32'h0);
    drive_j();
    step();
    check_eq("b2b_j", out_instr, 32'h0810_0000);
    check_eq("b2b_j_err", {31'h0, out_err}, 32'h0);
    drive_lw();
    step();
    in_valid = 1'b0;
    check_eq("b2b_lw", out_instr, 32'h8FA9_0004);
    check_eq("b2b_lw_err", {31'h0, out_err}, 32'h0);
    step();
    check_eq("b2b_empty", {31'h0, out_valid}, 32'h0);

    // Backpressure: fill, hold third word, then drain in order
    out_ready = 1'b0;
    drive_addu();
    step();
    check_eq("bp_ready_1", {31'h0, in_ready}, 32'h1);
    drive_addiu();
    step();
    check_eq("bp_ready_full", {31'h0, in_ready}, 32'h0);
    check_eq("bp_head_1", out_instr, 32'h0022_1821);
    drive_lw();
    step();
    check_eq("bp_ready_held", {31'h0, in_ready}, 32'h0);
    check_eq("bp_head_stable", out_instr, 32'h0022_1821);
    out_ready = 1'b1;
    step();
    check_eq("bp_ready_back", {31'h0, in_ready}, 32'h1);
    check_eq("bp_head_2", out_instr, 32'h2408_0005);
    step();
    in_valid = 1'b0;
    check_eq("bp_head_3", out_instr, 32'h8FA9_0004);
    step();
    check_eq("bp_empty", {31'h0, out_valid}, 32'h0);

    // Format mismatch: I tag with J opcode
    drive(2'd1, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0);
    step();
    check_eq("mm_instr", out_instr, 32'h0800_1234);
    check_eq("mm_err", {31'h0, out_err}, 32'h1);
    check_eq("mm_nochk_instr", nc_out_instr, 32'h0800_1234);
    check_eq("mm_nochk_err", {31'h0, nc_out_err}, 32'h0);
    // R tag with I opcode
    drive(2'd0, 6'h09, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h0, 26'h0);
    step();
    check_eq("mm_r_instr", out_instr, 32'h2422_1905);
    check_eq("mm_r_err", {31'h0, out_err}, 32'h1);
    // Reserved tag
    drive(2'd3, 6'h00, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'hFFFF, 26'h3FFFFFF);
    step();
    in_valid = 1'b0;
    check_eq("rsv_instr", out_instr, 32'h0);
    check_eq("rsv_err", {31'h0, out_err}, 32'h1);
    step();

    // Reset with two entries queued; the input that cycle must be dropped
    out_ready = 1'b0;
    drive_addu();
    step();
    drive_addiu();
    step();
    check_eq("pre_rst_full", {31'h0, in_ready}, 32'h0);
    rst = 1'b1;
    drive_lw();
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check_eq("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check_eq("mid_rst_ready", {31'h0, in_ready}, 32'h1);
    out_ready = 1'b1;
    step();
    check_eq("post_rst_no_stale", {31'h0, out_valid}, 32'h0);
    check_eq("post_rst_instr", out_instr, 32'h0);

`ifdef ENCODER_STATS_EN
    check_eq("stat_r_clr", {16'h0, stat_r}, 32'h0);
    check_eq("stat_err_clr", {16'h0, stat_err}, 32'h0);
    drive_addu();
    step();
    drive_addu();
    step();
    drive_addiu();
    step();
    drive(2'd2, 6'h09, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000123);
    step();
    in_valid = 1'b0;
    step();
    check_eq("stat_r", {16'h0, stat_r}, 32'h2);
    check_eq("stat_i", {16'h0, stat_i}, 32'h1);
    check_eq("stat_j", {16'h0, stat_j}, 32'h1);
    check_eq("stat_err", {16'h0, stat_err}, 32'h1);
    check_eq("stat_err_nochk", {16'h0, nc_stat_err}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
